mac_dot_seq: RTL

//   Feeder/collector for the signed 8x8 multiply-accumulator. Accepts operand pairs on a valid/ready stream.

---
 rtl/mac_dot_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/mac_dot_seq.sv
// Feeder/collector around a signed 8x8 multiply-accumulator: streams VEC_LEN
// operand pairs into the MAC, flushes its pipeline and returns one dot product.
module mac_dot_seq #(
  parameter int VEC_LEN = 4,
  parameter int DW      = 8,
  parameter int AW      = 18
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_a,
  input  logic signed [DW-1:0] in_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [AW-1:0] res_data,
  output logic signed [DW-1:0] mac_dataa,
  output logic signed [DW-1:0] mac_datab,
  output logic                 mac_clken,
  output logic                 mac_sload,
  input  logic signed [AW-1:0] mac_adder_out
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] LAST_IDX = 3'(VEC_LEN - 1);

  logic [1:0]          r_state;
  logic [2:0]          r_elem_cnt;
  logic                r_res_valid;
  logic signed [AW-1:0] r_res_data;

  logic w_in_ready;
  logic w_accept;

  // in_ready is gated by aclr_n so nothing is accepted while reset is held.
  assign w_in_ready = (r_state == S_RUN) & aclr_n & ~abort;
  assign w_accept   = in_valid & w_in_ready;

  assign in_ready  = w_in_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  always_comb begin
    mac_dataa = '0;
    mac_datab = '0;
    mac_clken = 1'b0;
    mac_sload = 1'b0;
    case (r_state)
      S_RUN: begin
        mac_dataa = in_a;
        mac_datab = in_b;
        mac_sload = (r_elem_cnt == 3'd0);
        mac_clken = w_accept;
      end
      // Zero operands clock the last product through without adding anything new.
      S_FLUSH: mac_clken = aclr_n;
      default: begin
        mac_clken = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= S_RUN;
      r_elem_cnt  <= 3'd0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (abort) begin
      r_state     <= S_RUN;
      r_elem_cnt  <= 3'd0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (r_elem_cnt == LAST_IDX) begin
              r_elem_cnt <= 3'd0;
              r_state    <= S_FLUSH;
            end else begin
              r_elem_cnt <= r_elem_cnt + 3'd1;
            end
          end
        end
        S_FLUSH: r_state <= S_CAPT;
        S_CAPT: begin
          r_res_data  <= mac_adder_out;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
